// File: rtl/mult3_event_fifo.sv
// Event FIFO capturing counter values flagged as multiples of 3, with overflow-drop
// and upstream counter wrap-around statistics.
module mult3_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         in_num,
  input  logic                     in_hit,
  input  logic                     in_en,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               wrap_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] prev_num_q;
  logic             prev_ok_q;
  logic [7:0]       drop_q, wrap_q;
  logic             push, pop, drop, wrap;

  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == FullLevel);
    out_valid = !empty;
    pop       = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push      = in_en & in_hit & (!full | pop);
    drop      = in_en & in_hit & full & !pop;
    wrap      = in_en & prev_ok_q & (in_num < prev_num_q);
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
    level     = level_q;
    drop_cnt  = drop_q;
    wrap_cnt  = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      prev_num_q <= '0;
      prev_ok_q  <= 1'b0;
      drop_q     <= '0;
      wrap_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (drop && drop_q != 8'hff) drop_q <= drop_q + 1'b1;
      if (wrap) wrap_q <= wrap_q + 1'b1;
      if (in_en) begin
        prev_num_q <= in_num;
        prev_ok_q  <= 1'b1;
      end
    end
  end

  // Storage needs no reset; empty masks stale contents on out_data.
  always_ff @(posedge clk) begin
    if (rstn && push) mem_q[wr_ptr_q] <= in_num;
  end

endmodule

// File: tb/tb_mult3_event_fifo.sv
// Bench for mult3_event_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult3_event_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] in_num = '0;
  logic             in_hit = 1'b0;
  logic             in_en = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       level;
  logic             full;
  logic             empty;
  logic [7:0]       drop_cnt;
  logic [7:0]       wrap_cnt;

  mult3_event_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_num   (in_num),
    .in_hit   (in_hit),
    .in_en    (in_en),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  int               m_drop;
  int               m_wrap;
  logic [WIDTH-1:0] m_prev;
  bit               m_prev_ok;
  bit               m_pop, m_full, m_push;
  logic [WIDTH-1:0] got[$];
  logic [WIDTH-1:0] exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_drop = 0;
      m_wrap = 0;
      m_prev = '0;
      m_prev_ok = 1'b0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_full = (mq.size() == DEPTH);
      m_push = in_en && in_hit && (!m_full || m_pop);
      if (in_en && in_hit && m_full && !m_pop && m_drop < 255) m_drop++;
      if (in_en && m_prev_ok && (in_num < m_prev)) m_wrap = (m_wrap + 1) % 256;
      if (in_en) begin
        m_prev = in_num;
        m_prev_ok = 1'b1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(in_num);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_head = (mq.size() != 0) ? mq[0] : '0;
      chk("level",     32'(level),     32'(mq.size()));
      chk("full",      32'(full),      32'(mq.size() == DEPTH));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data",  32'(out_data),  32'(exp_head));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
      chk("wrap_cnt",  32'(wrap_cnt),  32'(m_wrap));
      if (rstn && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic step(input bit r, input bit en, input int num, input bit hit, input bit rdy);
    @(posedge clk);
    #1;
    rstn      = r;
    in_en     = en;
    in_num    = WIDTH'(num);
    in_hit    = hit;
    out_ready = rdy;
  endtask

  int num;
  bit rdy;

  initial begin
    // Reset state
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_empty",     32'(empty),     1);
    chk("rst_level",     32'(level),     0);
    chk("rst_drop",      32'(drop_cnt),  0);

    // Counter 0..9, hits delivered immediately
    got.delete();
    for (int n = 0; n < 10; n++) step(1'b1, 1'b1, n, (n % 3) == 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("seq_count", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++) chk("seq_data", 32'(got[i]), 32'(3 * i));
    chk("seq_drop", 32'(drop_cnt), 0);

    // Overflow with consumer stalled, then push+pop while full
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    got.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 3 * i, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_full",  32'(full),     1);
    chk("ovf_level", 32'(level),    8);
    chk("ovf_drop",  32'(drop_cnt), 2);
    step(1'b1, 1'b1, 30, 1'b1, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pp_level", 32'(level),    8);
    chk("pp_drop",  32'(drop_cnt), 2);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_count", 32'(got.size()), 9);
    for (int i = 0; i < 8; i++) chk("drain_data", 32'(got[i]), 32'(3 * i));
    chk("drain_last", 32'(got[8]), 30);

    // Wrap counting
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 299, 1'b0, 1'b1);
    step(1'b1, 1'b1, 300, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_one", 32'(wrap_cnt), 1);
    for (int i = 0; i < 254; i++) begin
      step(1'b1, 1'b1, 300, 1'b1, 1'b1);
      step(1'b1, 1'b1, 0, 1'b1, 1'b1);
    end
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_255", 32'(wrap_cnt), 255);
    step(1'b1, 1'b1, 300, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_roll", 32'(wrap_cnt), 0);

    // Drop counter saturation
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 308; i++) step(1'b1, 1'b1, 3 * i, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("drop_full", 32'(full), 1);

    // Reset mid-operation
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3 * i + 30, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_level5", 32'(level), 5);
    step(1'b0, 1'b1, 99, 1'b1, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_level0", 32'(level), 0);
    chk("mid_valid",  32'(out_valid), 0);
    chk("mid_data",   32'(out_data), 0);
    step(1'b1, 1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("first_wrap", 32'(wrap_cnt), 0);
    chk("first_level", 32'(level), 1);

    // Randomized traffic with alternating consumer pressure
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0) num = int'($urandom_range(65535));
      else num = int'($urandom_range(40));
      if (((k / 250) % 2) == 0) rdy = ($urandom_range(3) == 0);
      else rdy = ($urandom_range(3) != 0);
      step($urandom_range(199) != 0, $urandom_range(3) != 0, num,
           ($urandom_range(9) == 0) ? 1'($urandom_range(1)) : ((num % 3) == 0), rdy);
    end
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
